csr_master: RTL
===============

// Module: csr_master
// PURPOSE
//  Bus-master (initiator) end of the bus_if CSR links into the matrix-vector controller. Takes one job
//  command (vector rows, matrix columns), writes row size, column size and run bit over three bus_if
//  master ports, clears the run bit once computation starts, then tracks the controller's read phase.
//  Sits between the host-side command interface and the accelerator controller.
// PARAMETERS
//  DATA_W     32    bus_if data width; sizes zero-extended into it, run bit is data[0]
//  TIMEOUT    1023  max cycles in any wait state before abort (15-bit counter, saturating compare)
// PORTS
//  clk          in   1       single clock, all logic on posedge
//  reset        in   1       asynchronous, active-high
//  cmd_valid    in   1       job request
//  cmd_ready    out  1       high only in IDLE; job accepted when cmd_valid & cmd_ready at posedge
//  cmd_rows     in   8       vector length, captured on accept
//  cmd_cols     in   8       matrix column count, captured on accept
//  vec_csr_if   bus_if.mst_port  drives valid,data; samples ready (row size register)
//  mat_csr_if   bus_if.mst_port  drives valid,data; samples ready (column size register)
//  csr_if       bus_if.mst_port  drives valid,data; samples ready (run control register)
//  read         in   1       controller result-read strobe
//  busy         out  1       high in every state except IDLE
//  done         out  1       1-cycle pulse on job completion
//  err          out  1       1-cycle pulse on timeout abort (mutually exclusive with done)
//  rd_count     out  9       read-strobe cycles counted in the current/last job
// BEHAVIOUR
//  Reset (async): state=IDLE; all valid=0, all data=0, cmd_ready=1, busy=0, done=0, err=0, rd_count=0.
//  Slave latches data on the RISING edge of valid, so every write is a fresh edge:
//   - data driven and stable >=1 cycle before valid rises; held until valid has fallen.
//   - handshaked write: valid rises, held until ready=1 sampled at a posedge, then valid=0 next cycle.
//   - posted write (run clear only): valid high exactly 1 cycle, ready ignored.
//   - valid low >=1 cycle between writes on the same port.
//  States (registered, one transition per cycle):
//   IDLE     cmd accept -> capture rows/cols, rd_count=0, -> VEC_SU
//   VEC_SU   vec data={0,rows} -> VEC_WR
//   VEC_WR   vec valid=1; on vec ready=1 -> MAT_SU
//   MAT_SU   vec valid=0; mat data={0,cols} -> MAT_WR
//   MAT_WR   mat valid=1; on mat ready=1 -> RUN_SU
//   RUN_SU   mat valid=0; csr data=1 -> RUN_WR
//   RUN_WR   csr valid=1; on csr ready=1 -> RUN_ACK
//   RUN_ACK  csr valid=0; wait csr ready=0 (controller in CAL) -> CLR_SU
//   CLR_SU   csr data=0 -> CLR_WR
//   CLR_WR   csr valid=1 for one cycle (posted) -> WAIT_RD
//   WAIT_RD  csr valid=0; on read=1 -> RD (that cycle counts: rd_count=1)
//   RD       rd_count++ each cycle read=1; on read=0 -> FIN
//   FIN      done=1 one cycle -> IDLE
//  Timeout: counter clears on each state change; in VEC_WR, MAT_WR, RUN_WR, RUN_ACK, WAIT_RD, RD,
//   when it reaches TIMEOUT: err=1, drop all valid, -> IDLE (rd_count holds value).
//  Expected rd_count at done = cols+1; any other value still completes (no check in RTL).
//  rd_count saturates at 511. cmd_rows/cols of 0 legal (rd_count=1 expected).
//  read=1 outside WAIT_RD/RD ignored. cmd_valid outside IDLE ignored (not queued).
//  Reset mid-job: immediate return to reset values; any valid drops asynchronously.
// TESTING
//  rows=4, cols=3, slave ready=1 -> three valid rising edges, data 4,3,1 then posted 0; rd_count=4; done pulse.
//  slave vec ready held 0 for 10 cycles -> vec valid stays high, data stable, no mat activity until ready.
//  vec ready stuck 0 -> err pulse after TIMEOUT cycles in VEC_WR, valid=0, cmd_ready=1 next cycle.
//  back-to-back jobs (2,2) then (5,1) -> valid low >=1 cycle between writes; rd_count 3 then 2.
//  reset asserted in RD -> all outputs to reset values same cycle; next job completes normally.
//  cmd_valid pulsed while busy -> ignored; only original job's writes seen.

Source files
------------

// File: rtl/bus_if.sv
// CSR link between an initiator and a register slave: valid/data from master, ready from slave.
// The slave latches data on the rising edge of valid.
interface bus_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport mst_port (output valid, output data, input ready);
    modport slv_port (input valid, input data, output ready);
endinterface

// File: rtl/csr_master.sv
// Initiator side of the matrix-vector controller CSR links: programs row/column sizes,
// pulses the run bit, then follows the controller's result-read phase.
module csr_master #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_rows,
    input  logic [7:0] cmd_cols,
    bus_if.mst_port    vec_csr_if,
    bus_if.mst_port    mat_csr_if,
    bus_if.mst_port    csr_if,
    input  logic       read,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [8:0] rd_count
);

    typedef enum logic [3:0] {
        IDLE, VEC_SU, VEC_WR, MAT_SU, MAT_WR, RUN_SU, RUN_WR,
        RUN_ACK, CLR_SU, CLR_WR, WAIT_RD, RD, FIN
    } state_t;

    localparam logic [14:0] TMO_LIM = 15'(TIMEOUT);
    localparam logic [14:0] TMO_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic              abort;
    logic [14:0]       tmo;
    logic [7:0]        cols_q;
    logic              vec_valid;
    logic              mat_valid;
    logic              csr_valid;
    logic [DATA_W-1:0] vec_data;
    logic [DATA_W-1:0] mat_data;
    logic [DATA_W-1:0] csr_data;

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = VEC_SU;
            VEC_SU:  state_nxt = VEC_WR;
            VEC_WR:  if (vec_csr_if.ready) state_nxt = MAT_SU;
                     else if (tmo >= TMO_LIM) abort = 1'b1;
            MAT_SU:  state_nxt = MAT_WR;
            MAT_WR:  if (mat_csr_if.ready) state_nxt = RUN_SU;
                     else if (tmo >= TMO_LIM) abort = 1'b1;
            RUN_SU:  state_nxt = RUN_WR;
            RUN_WR:  if (csr_if.ready) state_nxt = RUN_ACK;
                     else if (tmo >= TMO_LIM) abort = 1'b1;
            RUN_ACK: if (!csr_if.ready) state_nxt = CLR_SU;
                     else if (tmo >= TMO_LIM) abort = 1'b1;
            CLR_SU:  state_nxt = CLR_WR;
            CLR_WR:  state_nxt = WAIT_RD;
            WAIT_RD: if (read) state_nxt = RD;
                     else if (tmo >= TMO_LIM) abort = 1'b1;
            RD:      if (!read) state_nxt = FIN;
                     else if (tmo >= TMO_LIM) abort = 1'b1;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Valids come from the next state so each one is a clean register output; data registers
    // load only while the matching valid is low, giving a full cycle of setup before it rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tmo       <= '0;
            cols_q    <= '0;
            err       <= 1'b0;
            rd_count  <= '0;
            vec_valid <= 1'b0;
            mat_valid <= 1'b0;
            csr_valid <= 1'b0;
            vec_data  <= '0;
            mat_data  <= '0;
            csr_data  <= '0;
        end else begin
            state     <= state_nxt;
            err       <= abort;
            vec_valid <= (state_nxt == VEC_WR);
            mat_valid <= (state_nxt == MAT_WR);
            csr_valid <= (state_nxt == RUN_WR) || (state_nxt == CLR_WR);

            if (state_nxt != state)
                tmo <= '0;
            else if (tmo != TMO_MAX)
                tmo <= tmo + 15'd1;

            if (state == IDLE && cmd_valid) begin
                vec_data <= {{(DATA_W-8){1'b0}}, cmd_rows};
                cols_q   <= cmd_cols;
                rd_count <= '0;
            end
            if (state == VEC_WR && state_nxt == MAT_SU)
                mat_data <= {{(DATA_W-8){1'b0}}, cols_q};
            if (state == MAT_WR && state_nxt == RUN_SU)
                csr_data <= {{(DATA_W-1){1'b0}}, 1'b1};
            if (state == RUN_ACK && state_nxt == CLR_SU)
                csr_data <= '0;

            // The read cycle that leaves WAIT_RD is the first counted one.
            if (state == WAIT_RD && read)
                rd_count <= 9'd1;
            else if (state == RD && read && !abort && rd_count != 9'd511)
                rd_count <= rd_count + 9'd1;
        end
    end

    assign cmd_ready        = (state == IDLE);
    assign busy             = (state != IDLE);
    assign done             = (state == FIN);
    assign vec_csr_if.valid = vec_valid;
    assign vec_csr_if.data  = vec_data;
    assign mat_csr_if.valid = mat_valid;
    assign mat_csr_if.data  = mat_data;
    assign csr_if.valid     = csr_valid;
    assign csr_if.data      = csr_data;

endmodule
